// File: rtl/dcache_ctrl.sv
// Miss/writeback controller between the memory stage and a direct-mapped
// data cache array: performs lookups, fills lines on read misses and
// evicts dirty victims to memory before replacing them.
module dcache_ctrl #(
  parameter int unsigned IDX_BITS = 7,
  parameter int unsigned TAG_BITS = 22,
  parameter int unsigned DATA_W   = 64,
  parameter int unsigned MTAG_W   = 4
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                proc_rd_en,
  input  logic                proc_wr_en,
  input  logic [31:0]         proc_addr,
  input  logic [DATA_W-1:0]   proc_wr_data,
  output logic                proc_ready,
  output logic                proc_valid,
  output logic [DATA_W-1:0]   proc_data,
  output logic [IDX_BITS-1:0] cache_rd_idx,
  output logic [TAG_BITS-1:0] cache_rd_tag,
  input  logic                cache_rd_valid,
  input  logic [DATA_W-1:0]   cache_rd_data,
  input  logic                cache_vic_valid,
  input  logic                cache_vic_dirty,
  input  logic [TAG_BITS-1:0] cache_vic_tag,
  output logic                cache_wr_en,
  output logic [IDX_BITS-1:0] cache_wr_idx,
  output logic [TAG_BITS-1:0] cache_wr_tag,
  output logic [DATA_W-1:0]   cache_wr_data,
  output logic                cache_wr_dirty,
  output logic [1:0]          mem_command,
  output logic [31:0]         mem_addr,
  output logic [DATA_W-1:0]   mem_data_out,
  input  logic [MTAG_W-1:0]   mem_response,
  input  logic [MTAG_W-1:0]   mem_tag,
  input  logic [DATA_W-1:0]   mem_data_in
);

  localparam int unsigned ADDR_W   = 32;
  localparam int unsigned OFF_BITS = 3;
  localparam logic [1:0]  MEM_NONE  = 2'd0;
  localparam logic [1:0]  MEM_LOAD  = 2'd1;
  localparam logic [1:0]  MEM_STORE = 2'd2;

  typedef enum logic [2:0] {
    S_IDLE, S_LOOKUP, S_WB, S_FILL, S_WAIT, S_RESP
  } state_e;

  state_e              state_q, state_d;
  logic [IDX_BITS-1:0] req_idx_q, req_idx_d;
  logic [TAG_BITS-1:0] req_tag_q, req_tag_d;
  logic                req_wr_q, req_wr_d;
  logic [DATA_W-1:0]   req_data_q, req_data_d;
  logic [TAG_BITS-1:0] vic_tag_q, vic_tag_d;
  logic [DATA_W-1:0]   vic_data_q, vic_data_d;
  logic [MTAG_W-1:0]   wait_tag_q, wait_tag_d;
  logic [DATA_W-1:0]   proc_data_q, proc_data_d;
  logic                proc_valid_q, proc_valid_d;
  logic                dirty_vic;

  // Byte-offset bits carry no information for a 64-bit line.
  logic unused_addr_bits;
  assign unused_addr_bits = ^proc_addr[OFF_BITS-1:0];

  assign proc_valid = proc_valid_q;
  assign proc_data  = proc_data_q;

  // A valid dirty line holding a different tag must be written back first.
  assign dirty_vic = cache_vic_valid & cache_vic_dirty & (cache_vic_tag != req_tag_q);

  // State and request/victim registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q      <= S_IDLE;
      req_idx_q    <= '0;
      req_tag_q    <= '0;
      req_wr_q     <= 1'b0;
      req_data_q   <= '0;
      vic_tag_q    <= '0;
      vic_data_q   <= '0;
      wait_tag_q   <= '0;
      proc_data_q  <= '0;
      proc_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      req_idx_q    <= req_idx_d;
      req_tag_q    <= req_tag_d;
      req_wr_q     <= req_wr_d;
      req_data_q   <= req_data_d;
      vic_tag_q    <= vic_tag_d;
      vic_data_q   <= vic_data_d;
      wait_tag_q   <= wait_tag_d;
      proc_data_q  <= proc_data_d;
      proc_valid_q <= proc_valid_d;
    end
  end

  // Next-state logic plus array-write and memory-bus outputs.
  always_comb begin
    state_d        = state_q;
    req_idx_d      = req_idx_q;
    req_tag_d      = req_tag_q;
    req_wr_d       = req_wr_q;
    req_data_d     = req_data_q;
    vic_tag_d      = vic_tag_q;
    vic_data_d     = vic_data_q;
    wait_tag_d     = wait_tag_q;
    proc_data_d    = proc_data_q;
    proc_ready     = 1'b0;
    cache_rd_idx   = req_idx_q;
    cache_rd_tag   = req_tag_q;
    cache_wr_en    = 1'b0;
    cache_wr_idx   = req_idx_q;
    cache_wr_tag   = req_tag_q;
    cache_wr_data  = '0;
    cache_wr_dirty = 1'b0;
    mem_command    = MEM_NONE;
    mem_addr       = '0;
    mem_data_out   = '0;

    unique case (state_q)
      S_IDLE: begin
        proc_ready   = 1'b1;
        cache_rd_idx = proc_addr[OFF_BITS +: IDX_BITS];
        cache_rd_tag = proc_addr[OFF_BITS+IDX_BITS +: TAG_BITS];
        if (proc_rd_en || proc_wr_en) begin
          req_idx_d  = proc_addr[OFF_BITS +: IDX_BITS];
          req_tag_d  = proc_addr[OFF_BITS+IDX_BITS +: TAG_BITS];
          req_wr_d   = proc_wr_en;
          req_data_d = proc_wr_data;
          state_d    = S_LOOKUP;
        end
      end
      S_LOOKUP: begin
        if (req_wr_q && !dirty_vic) begin
          cache_wr_en    = 1'b1;
          cache_wr_data  = req_data_q;
          cache_wr_dirty = 1'b1;
          state_d        = S_RESP;
        end else if (dirty_vic) begin
          vic_tag_d  = cache_vic_tag;
          vic_data_d = cache_rd_data;
          state_d    = S_WB;
        end else if (cache_rd_valid) begin
          proc_data_d = cache_rd_data;
          state_d     = S_RESP;
        end else begin
          state_d = S_FILL;
        end
      end
      S_WB: begin
        mem_command  = MEM_STORE;
        mem_addr     = ADDR_W'({vic_tag_q, req_idx_q, {OFF_BITS{1'b0}}});
        mem_data_out = vic_data_q;
        if (mem_response != '0) begin
          if (req_wr_q) begin
            cache_wr_en    = 1'b1;
            cache_wr_data  = req_data_q;
            cache_wr_dirty = 1'b1;
            state_d        = S_RESP;
          end else begin
            state_d = S_FILL;
          end
        end
      end
      S_FILL: begin
        mem_command = MEM_LOAD;
        mem_addr    = ADDR_W'({req_tag_q, req_idx_q, {OFF_BITS{1'b0}}});
        if (mem_response != '0) begin
          wait_tag_d = mem_response;
          state_d    = S_WAIT;
        end
      end
      S_WAIT: begin
        // Only the tag of our own outstanding load completes the fill.
        if ((mem_tag == wait_tag_q) && (mem_tag != '0)) begin
          cache_wr_en    = 1'b1;
          cache_wr_data  = mem_data_in;
          cache_wr_dirty = 1'b0;
          proc_data_d    = mem_data_in;
          state_d        = S_RESP;
        end
      end
      S_RESP: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    proc_valid_d = (state_d == S_RESP);
  end

endmodule

// File: tb/tb_dcache_ctrl.sv
// Randomized bench for dcache_ctrl: behavioural cache array and memory,
// a coherent address->data reference view, and a scoreboard monitor.
module tb_dcache_ctrl;

  localparam int unsigned IDX_BITS = 7;
  localparam int unsigned TAG_BITS = 22;
  localparam int unsigned DATA_W   = 64;
  localparam int unsigned MTAG_W   = 4;
  localparam int unsigned NLINES   = 128;
  localparam int unsigned NREQ     = 400;

  logic                clk, rst_n;
  logic                proc_rd_en, proc_wr_en;
  logic [31:0]         proc_addr;
  logic [DATA_W-1:0]   proc_wr_data;
  logic                proc_ready, proc_valid;
  logic [DATA_W-1:0]   proc_data;
  logic [IDX_BITS-1:0] cache_rd_idx;
  logic [TAG_BITS-1:0] cache_rd_tag;
  logic                cache_rd_valid;
  logic [DATA_W-1:0]   cache_rd_data;
  logic                cache_vic_valid, cache_vic_dirty;
  logic [TAG_BITS-1:0] cache_vic_tag;
  logic                cache_wr_en;
  logic [IDX_BITS-1:0] cache_wr_idx;
  logic [TAG_BITS-1:0] cache_wr_tag;
  logic [DATA_W-1:0]   cache_wr_data;
  logic                cache_wr_dirty;
  logic [1:0]          mem_command;
  logic [31:0]         mem_addr;
  logic [DATA_W-1:0]   mem_data_out;
  logic [MTAG_W-1:0]   mem_response, mem_tag;
  logic [DATA_W-1:0]   mem_data_in;

  dcache_ctrl dut (
    .clock(clk), .reset(rst_n),
    .proc_rd_en(proc_rd_en), .proc_wr_en(proc_wr_en), .proc_addr(proc_addr),
    .proc_wr_data(proc_wr_data), .proc_ready(proc_ready), .proc_valid(proc_valid),
    .proc_data(proc_data), .cache_rd_idx(cache_rd_idx), .cache_rd_tag(cache_rd_tag),
    .cache_rd_valid(cache_rd_valid), .cache_rd_data(cache_rd_data),
    .cache_vic_valid(cache_vic_valid), .cache_vic_dirty(cache_vic_dirty),
    .cache_vic_tag(cache_vic_tag), .cache_wr_en(cache_wr_en), .cache_wr_idx(cache_wr_idx),
    .cache_wr_tag(cache_wr_tag), .cache_wr_data(cache_wr_data),
    .cache_wr_dirty(cache_wr_dirty), .mem_command(mem_command), .mem_addr(mem_addr),
    .mem_data_out(mem_data_out), .mem_response(mem_response), .mem_tag(mem_tag),
    .mem_data_in(mem_data_in)
  );

  typedef struct {
    bit          is_rd;
    logic [31:0] addr;
    logic [63:0] data;
    int unsigned cyc;
    bit          fast;
  } exp_t;

  exp_t        sb_q[$];
  logic [63:0] ref_wr [logic [31:0]];
  logic [63:0] mem_bk [logic [31:0]];
  int          n_checks = 0;
  int          n_fail = 0;
  int unsigned cyc = 0;

  logic                c_valid [NLINES];
  logic                c_dirty [NLINES];
  logic [TAG_BITS-1:0] c_tag   [NLINES];
  logic [DATA_W-1:0]   c_data  [NLINES];

  bit                mem_slow = 1'b0;
  bit                pend = 1'b0;
  logic [MTAG_W-1:0] pend_tag = '0;
  logic [31:0]       pend_addr = '0;
  int                pend_cnt = 0;

  // Initial array contents, derived from the line index.
  function automatic bit pre_valid(int i); return (i % 4) != 3; endfunction
  function automatic bit pre_dirty(int i); return (i % 2) == 0; endfunction
  function automatic logic [TAG_BITS-1:0] pre_tag(int i); return 22'(i % 3); endfunction
  function automatic logic [63:0] dirty_data(int i);
    return {32'hD1D1_0000 + 32'(i), 32'hCAFE_0000 + 32'(i)};
  endfunction
  function automatic logic [63:0] base_data(logic [31:0] a);
    return {a, a ^ 32'h5A5A_A5A5};
  endfunction

  // Architecturally visible value of an address (last store wins).
  function automatic logic [63:0] ref_read(logic [31:0] a_in);
    logic [31:0] a;
    int          i;
    a = a_in & 32'hFFFF_FFF8;
    i = int'(a[9:3]);
    if (ref_wr.exists(a)) return ref_wr[a];
    if (pre_valid(i) && pre_dirty(i) && (pre_tag(i) == a[31:10])) return dirty_data(i);
    return base_data(a);
  endfunction

  function automatic logic [63:0] mem_rd(logic [31:0] a);
    if (mem_bk.exists(a)) return mem_bk[a];
    return base_data(a);
  endfunction

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  task automatic fail_now(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s (cycle %0d)", name, cyc);
  endtask

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural array: combinational lookup, writes applied just after the edge.
  assign cache_rd_valid  = c_valid[cache_rd_idx] && (c_tag[cache_rd_idx] == cache_rd_tag);
  assign cache_rd_data   = c_data[cache_rd_idx];
  assign cache_vic_valid = c_valid[cache_rd_idx];
  assign cache_vic_dirty = c_dirty[cache_rd_idx];
  assign cache_vic_tag   = c_tag[cache_rd_idx];

  initial begin
    bit                  w_en;
    logic [IDX_BITS-1:0] w_idx;
    logic [TAG_BITS-1:0] w_tag;
    logic [DATA_W-1:0]   w_data;
    logic                w_dirty;
    for (int i = 0; i < int'(NLINES); i++) begin
      c_valid[i] = pre_valid(i);
      c_dirty[i] = pre_valid(i) && pre_dirty(i);
      c_tag[i]   = pre_tag(i);
      c_data[i]  = pre_dirty(i) ? dirty_data(i) : base_data({pre_tag(i), 7'(i), 3'b000});
    end
    forever begin
      @(negedge clk);
      w_en = rst_n && cache_wr_en;
      w_idx = cache_wr_idx; w_tag = cache_wr_tag; w_data = cache_wr_data; w_dirty = cache_wr_dirty;
      @(posedge clk);
      #1;
      if (w_en) begin
        c_valid[w_idx] = 1'b1;
        c_dirty[w_idx] = w_dirty;
        c_tag[w_idx]   = w_tag;
        c_data[w_idx]  = w_data;
      end
    end
  end

  // Memory: random accept/refuse, random return delay, foreign tag noise.
  initial begin
    logic [MTAG_W-1:0] next_tag;
    logic [MTAG_W-1:0] ft;
    next_tag = 4'd1;
    mem_response = '0; mem_tag = '0; mem_data_in = '0;
    forever begin
      @(posedge clk);
      #1;
      mem_response = '0;
      mem_tag      = '0;
      mem_data_in  = {$urandom, $urandom};
      if (pend) begin
        if (pend_cnt == 0) begin
          mem_tag     = pend_tag;
          mem_data_in = mem_rd(pend_addr);
          pend        = 1'b0;
        end else begin
          pend_cnt--;
        end
      end
      if (mem_tag == '0 && !mem_slow && $urandom_range(0, 9) < 3) begin
        ft = 4'($urandom_range(1, 15));
        if (ft == pend_tag) ft = (ft == 4'd15) ? 4'd1 : ft + 4'd1;
        mem_tag = ft;
      end
      if (mem_command != 2'd0 && (mem_slow || $urandom_range(0, 9) < 6)) begin
        mem_response = next_tag;
        next_tag = (next_tag == 4'd15) ? 4'd1 : next_tag + 4'd1;
        if (sb_q.size() == 0) begin
          fail_now("mem_req_without_request");
        end else if (mem_command == 2'd2) begin
          check("store_idx", 64'(mem_addr[9:3]), 64'(sb_q[0].addr[9:3]));
          check("store_data", mem_data_out, ref_read(mem_addr));
          mem_bk[mem_addr] = mem_data_out;
        end else if (mem_command == 2'd1) begin
          check("load_addr", 64'(mem_addr), 64'(sb_q[0].addr));
          check("load_overlap", 64'(pend), 64'(0));
          pend      = 1'b1;
          pend_tag  = mem_response;
          pend_addr = mem_addr;
          pend_cnt  = mem_slow ? 12 : int'($urandom_range(0, 5));
        end else begin
          fail_now("mem_command_illegal");
        end
      end
    end
  end

  // Scoreboard monitor: array writes and completions against the reference view.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (cache_wr_en) begin
          if (sb_q.size() == 0) begin
            fail_now("unexpected_cache_write");
          end else begin
            e = sb_q[0];
            check("wr_idx", 64'(cache_wr_idx), 64'(e.addr[9:3]));
            check("wr_tag", 64'(cache_wr_tag), 64'(e.addr[31:10]));
            check("wr_dirty", 64'(cache_wr_dirty), 64'(!e.is_rd));
            check("wr_data", cache_wr_data, ref_read(e.addr));
          end
        end
        if (proc_valid) begin
          if (sb_q.size() == 0) begin
            fail_now("unexpected_proc_valid");
          end else begin
            e = sb_q.pop_front();
            if (e.is_rd) check("rd_data", proc_data, e.data);
            if (e.fast) check("latency", 64'(cyc), 64'(e.cyc + 2));
            else        check("latency_min", 64'(cyc > e.cyc + 2), 64'(1));
          end
        end
      end
    end
  end

  task automatic drive_idle();
    proc_rd_en = 1'b0; proc_wr_en = 1'b0; proc_addr = '0; proc_wr_data = '0;
  endtask

  // Issue one request in an IDLE cycle and record what it must produce.
  task automatic issue(input bit wr, input bit both, input logic [31:0] a, input logic [63:0] d);
    exp_t        e;
    logic [31:0] la;
    int          i;
    la = a & 32'hFFFF_FFF8;
    i  = int'(la[9:3]);
    e.is_rd = !wr;
    e.addr  = la;
    e.cyc   = cyc;
    if (wr) begin
      e.fast = !(c_valid[i] && c_dirty[i] && (c_tag[i] != la[31:10]));
      ref_wr[la] = d;
      e.data = d;
    end else begin
      e.fast = c_valid[i] && (c_tag[i] == la[31:10]);
      e.data = ref_read(la);
    end
    sb_q.push_back(e);
    proc_wr_en = wr; proc_rd_en = !wr || both; proc_addr = a; proc_wr_data = d;
  endtask

  initial begin
    int                issued, stall, seen;
    bit                aborted, reached;
    logic [MTAG_W-1:0] abandoned;
    rst_n = 1'b0;
    drive_idle();
    repeat (3) @(negedge clk);
    check("rst_ready", 64'(proc_ready), 64'(1));
    check("rst_valid", 64'(proc_valid), 64'(0));
    check("rst_data", proc_data, 64'(0));
    check("rst_cmd", 64'(mem_command), 64'(0));
    check("rst_wr_en", 64'(cache_wr_en), 64'(0));
    rst_n = 1'b1;

    issued = 0; stall = 0; aborted = 1'b0;
    while (issued < int'(NREQ) && !aborted) begin
      @(negedge clk);
      if (proc_ready) begin
        stall = 0;
        if ($urandom_range(0, 3) == 0) begin
          drive_idle();
        end else begin
          issue(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                {22'($urandom_range(0, 3)), 7'($urandom_range(0, 7)), 3'($urandom)},
                {$urandom, $urandom});
          issued++;
        end
      end else begin
        // Strobes while busy must be ignored, never queued.
        proc_rd_en = 1'($urandom); proc_wr_en = 1'($urandom);
        proc_addr = $urandom; proc_wr_data = {$urandom, $urandom};
        stall++;
        if (stall > 300) begin
          fail_now("ready_timeout");
          aborted = 1'b1;
        end
      end
    end
    for (int k = 0; k < 300 && sb_q.size() != 0; k++) begin
      @(negedge clk);
      drive_idle();
    end
    if (sb_q.size() != 0) fail_now("drain_timeout");

    // Abort a read miss with reset while its fill is outstanding.
    mem_slow = 1'b1;
    @(negedge clk);
    drive_idle();
    for (int k = 0; k < 50 && !proc_ready; k++) @(negedge clk);
    issue(1'b0, 1'b0, {22'h3, 7'd100, 3'b000}, 64'h0);
    reached = 1'b0;
    for (int k = 0; k < 100 && !reached; k++) begin
      @(negedge clk);
      drive_idle();
      reached = pend && (mem_command == 2'd0) && !proc_ready;
    end
    if (!reached) fail_now("wait_state_not_reached");
    #2;
    rst_n = 1'b0;
    abandoned = pend_tag;
    sb_q.delete();
    #1;
    check("arst_ready", 64'(proc_ready), 64'(1));
    check("arst_cmd", 64'(mem_command), 64'(0));
    check("arst_valid", 64'(proc_valid), 64'(0));
    check("arst_wr_en", 64'(cache_wr_en), 64'(0));
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (reached && mem_tag == abandoned && seen == 0) begin
        check("stale_tag_wr_en", 64'(cache_wr_en), 64'(0));
        check("stale_tag_ready", 64'(proc_ready), 64'(1));
        seen = 1;
      end
    end
    if (reached && seen == 0) fail_now("stale_tag_not_returned");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
